// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage for the five-stage MIPS pipeline.
// Keeps up to MAX_OUTSTANDING requests in flight on the SRAM-like interface
// and buffers returned instructions in an IBUF_DEPTH-entry queue. Branch,
// exception and eret redirects drop younger work but keep the delay slot.
// Optional feature macro: FETCH_ADEL_CHECK_EN (misaligned fetch raises AdEL).
module if_fetch_unit #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter logic [31:0] EX_PC           = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_ex,
  output logic [4:0]  fs_excode
);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  function automatic logic [IW-1:0] q_inc(input logic [IW-1:0] p);
    return (p == IW'(IBUF_DEPTH - 1)) ? {IW{1'b0}} : p + IW'(1);
  endfunction

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          redir_pend_q, redir_pend_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          ds_pend_q, ds_pend_d;
  logic [OW-1:0] cancel_q, cancel_d;
  logic [31:0]   pcf_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0] pcf_wr_q, pcf_rd_q;
  logic [OW-1:0] outst_q, outst_nxt_s;
  logic [31:0]   q_pc_q [IBUF_DEPTH];
  logic [31:0]   q_inst_q [IBUF_DEPTH];
  logic [IW-1:0] q_head_q, q_head_d, q_tail_s;
  logic [QW-1:0] q_cnt_q, q_cnt_d;
  logic [QW:0]   q_sum_s, credit_sum_s;
  logic          credit_ok_s, req_fire_s, rsp_s, rsp_keep_s, deq_s, flush_s;
  logic          enq_s;
  logic [31:0]   enq_pc_s, enq_inst_s;
`ifdef FETCH_ADEL_CHECK_EN
  logic          q_ex_q [IBUF_DEPTH];
  logic          adel_stall_q, adel_stall_d, adel_fire_s, misalign_s, enq_ex_s;
`endif

  assign credit_sum_s = (QW+1)'(outst_q) + (QW+1)'(q_cnt_q);
  assign credit_ok_s  = (outst_q < OW'(MAX_OUTSTANDING)) && (credit_sum_s < (QW+1)'(IBUF_DEPTH));
`ifdef FETCH_ADEL_CHECK_EN
  assign misalign_s    = (fetch_pc_q[1:0] != 2'b00);
  assign inst_sram_req = credit_ok_s && !misalign_s && !adel_stall_q;
  // The AdEL entry waits for older requests to drain so it stays in program order.
  assign adel_fire_s   = misalign_s && !adel_stall_q && (outst_q == OW'(0)) &&
                         (q_cnt_q < QW'(IBUF_DEPTH)) && !flush_s && !br_taken;
`else
  assign inst_sram_req = credit_ok_s;
`endif
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc_q;

  assign req_fire_s  = inst_sram_req && inst_sram_addr_ok;
  assign rsp_s       = inst_sram_data_ok && (outst_q != OW'(0));
  assign rsp_keep_s  = rsp_s && (ds_pend_q || (cancel_q == OW'(0)));
  assign deq_s       = fs_to_ds_valid && ds_allowin;
  assign flush_s     = ws_ex || ws_eret;
  assign outst_nxt_s = outst_q + OW'(req_fire_s) - OW'(rsp_s);
  assign q_sum_s     = (QW+1)'(q_head_q) + (QW+1)'(q_cnt_q);
  assign q_tail_s    = (q_sum_s >= (QW+1)'(IBUF_DEPTH)) ?
                       IW'(q_sum_s - (QW+1)'(IBUF_DEPTH)) : IW'(q_sum_s);

  assign fs_to_ds_valid = (q_cnt_q != QW'(0));
  assign fs_pc          = q_pc_q[q_head_q];
  assign fs_inst        = q_inst_q[q_head_q];
`ifdef FETCH_ADEL_CHECK_EN
  assign fs_ex          = q_ex_q[q_head_q];
  assign fs_excode      = q_ex_q[q_head_q] ? 5'h04 : 5'h00;
`else
  assign fs_ex          = 1'b0;
  assign fs_excode      = 5'h00;
`endif

  // Next-state for fetch PC, redirects, cancellation and queue occupancy
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    ds_pend_d    = ds_pend_q;
    cancel_d     = cancel_q;
    enq_s        = rsp_keep_s;
    enq_pc_s     = pcf_mem_q[pcf_rd_q];
    enq_inst_s   = inst_sram_rdata;
`ifdef FETCH_ADEL_CHECK_EN
    adel_stall_d = adel_stall_q;
    enq_ex_s     = 1'b0;
`endif
    if (req_fire_s) begin
      if (redir_pend_q) begin
        fetch_pc_d   = redir_pc_q;
        redir_pend_d = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    // A kept delay-slot response comes ahead of the cancelled ones behind it.
    if (rsp_s) begin
      if (ds_pend_q) begin
        ds_pend_d = 1'b0;
      end else if (cancel_q != OW'(0)) begin
        cancel_d = cancel_q - OW'(1);
      end else begin
        cancel_d = cancel_q;
      end
    end else begin
      cancel_d = cancel_q;
    end
`ifdef FETCH_ADEL_CHECK_EN
    if (adel_fire_s) begin
      enq_s        = 1'b1;
      enq_pc_s     = fetch_pc_q;
      enq_inst_s   = 32'h0;
      enq_ex_s     = 1'b1;
      adel_stall_d = 1'b1;
    end else begin
      enq_ex_s = 1'b0;
    end
`endif
    q_head_d = deq_s ? q_inc(q_head_q) : q_head_q;
    q_cnt_d  = q_cnt_q + QW'(enq_s) - QW'(deq_s);

    if (flush_s) begin
      fetch_pc_d   = ws_ex ? EX_PC : cp0_epc;
      redir_pend_d = 1'b0;
      ds_pend_d    = 1'b0;
      cancel_d     = outst_nxt_s;
      enq_s        = 1'b0;
      q_cnt_d      = QW'(0);
`ifdef FETCH_ADEL_CHECK_EN
      adel_stall_d = 1'b0;
`endif
    end else if (br_taken) begin
      if (q_cnt_q != QW'(0)) begin
        // Head of the queue is the delay slot; everything younger goes.
        fetch_pc_d   = br_target;
        redir_pend_d = 1'b0;
        ds_pend_d    = 1'b0;
        cancel_d     = outst_nxt_s;
        enq_s        = 1'b0;
        q_cnt_d      = deq_s ? QW'(0) : QW'(1);
      end else if (outst_q != OW'(0)) begin
        fetch_pc_d   = br_target;
        redir_pend_d = 1'b0;
        if (rsp_keep_s) begin
          ds_pend_d = 1'b0;
          cancel_d  = outst_nxt_s;
        end else begin
          ds_pend_d = (outst_nxt_s != OW'(0));
          cancel_d  = (outst_nxt_s != OW'(0)) ? outst_nxt_s - OW'(1) : OW'(0);
        end
      end else if (req_fire_s) begin
        // The request issued this cycle is the delay slot.
        fetch_pc_d   = br_target;
        redir_pend_d = 1'b0;
      end else begin
        redir_pend_d = 1'b1;
        redir_pc_d   = br_target;
      end
    end else begin
      redir_pc_d = redir_pc_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      ds_pend_q    <= 1'b0;
      cancel_q     <= {OW{1'b0}};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ds_pend_q    <= ds_pend_d;
      cancel_q     <= cancel_d;
    end
  end

  // PC FIFO of outstanding request addresses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) pcf_mem_q[i] <= 32'h0;
      pcf_wr_q <= {PW{1'b0}};
      pcf_rd_q <= {PW{1'b0}};
      outst_q  <= {OW{1'b0}};
    end else begin
      if (req_fire_s) begin
        pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
        pcf_wr_q            <= pcf_inc(pcf_wr_q);
      end
      if (rsp_s) pcf_rd_q <= pcf_inc(pcf_rd_q);
      outst_q <= outst_nxt_s;
    end
  end

  // Instruction queue storage and pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        q_pc_q[i]   <= 32'h0;
        q_inst_q[i] <= 32'h0;
      end
      q_head_q <= {IW{1'b0}};
      q_cnt_q  <= {QW{1'b0}};
    end else begin
      if (enq_s) begin
        q_pc_q[q_tail_s]   <= enq_pc_s;
        q_inst_q[q_tail_s] <= enq_inst_s;
      end
      q_head_q <= q_head_d;
      q_cnt_q  <= q_cnt_d;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  // Exception flag per queue entry and the post-AdEL issue stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < IBUF_DEPTH; i++) q_ex_q[i] <= 1'b0;
      adel_stall_q <= 1'b0;
    end else begin
      if (enq_s) q_ex_q[q_tail_s] <= enq_ex_s;
      adel_stall_q <= adel_stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with a latency-configurable memory
// responder; instruction data returned for address A is A + 32'h10000000.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        ws_ex = 1'b0;
  logic        ws_eret = 1'b0;
  logic [31:0] cp0_epc = 32'h0;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        fs_to_ds_valid, fs_ex;
  logic [31:0] fs_pc, fs_inst;
  logic [4:0]  fs_excode;

  if_fetch_unit dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
    .br_taken(br_taken), .br_target(br_target),
    .ws_ex(ws_ex), .ws_eret(ws_eret), .cp0_epc(cp0_epc),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .fs_ex(fs_ex), .fs_excode(fs_excode)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  int          cyc = 0;
  int          mem_lat = 1;
  logic        mem_hold = 1'b0;
  logic [31:0] mem_hold_addr = 32'hffffffff;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];
  logic        dlv_ex[$];
  logic [4:0]  dlv_code[$];
  int          dlv_cyc[$];

  // Free-running edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder (drives at negedge) and recorder of next-edge transfers
  always @(negedge clk) begin
    if (!resetn) begin
      pend_addr.delete();
      pend_due.delete();
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc + 1 &&
                 !(mem_hold && pend_addr[0] >= mem_hold_addr)) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = pend_addr[0] + 32'h10000000;
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'hdeadbeef;
    end
    #1;
    if (resetn) begin
      if (inst_sram_data_ok) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        pend_addr.push_back(inst_sram_addr);
        pend_due.push_back(cyc + 1 + mem_lat);
        acc_log.push_back(inst_sram_addr);
      end
      if (fs_to_ds_valid && ds_allowin) begin
        dlv_pc.push_back(fs_pc);
        dlv_inst.push_back(fs_inst);
        dlv_ex.push_back(fs_ex);
        dlv_code.push_back(fs_excode);
        dlv_cyc.push_back(cyc);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    acc_log.delete();
    dlv_pc.delete();
    dlv_inst.delete();
    dlv_ex.delete();
    dlv_code.delete();
    dlv_cyc.delete();
    run(3);
    resetn = 1'b1;
  endtask

  // Branch with two requests held in memory at 0x...10 and 0x...14
  task automatic branch_setup(input logic [31:0] target);
    ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; mem_lat = 1;
    mem_hold = 1'b1; mem_hold_addr = 32'hbfc00010;
    do_reset();
    run(14);
    check_eq("br_dlv_before", dlv_pc.size(), 32'd4);
    check_eq("br_acc_before", acc_log.size(), 32'd6);
    check_eq("br_req_low", inst_sram_req, 32'd0);
    check_eq("br_q_empty", fs_to_ds_valid, 32'd0);
    br_taken = 1'b1; br_target = target;
    run(1);
    br_taken = 1'b0; mem_hold = 1'b0;
    run(12);
  endtask

  int idx;
  int n102;

  initial begin
    // Reset values
    inst_sram_addr_ok = 1'b0;
    do_reset();
    #2;
    check_eq("rst_valid", fs_to_ds_valid, 32'd0);
    check_eq("rst_pc", fs_pc, 32'h0);
    check_eq("rst_inst", fs_inst, 32'h0);
    check_eq("rst_ex", fs_ex, 32'd0);
    check_eq("rst_excode", fs_excode, 32'd0);
    check_eq("rst_req", inst_sram_req, 32'd1);
    check_eq("rst_addr", inst_sram_addr, 32'hbfc00000);
    check_eq("const_size", inst_sram_size, 32'd2);
    check_eq("const_wr", inst_sram_wr, 32'd0);

    // Streaming at one instruction per cycle
    @(negedge clk);
    inst_sram_addr_ok = 1'b1; ds_allowin = 1'b1; mem_lat = 1;
    run(12);
    check_eq("t1_pc0", dlv_pc[0], 32'hbfc00000);
    check_eq("t1_pc1", dlv_pc[1], 32'hbfc00004);
    check_eq("t1_pc2", dlv_pc[2], 32'hbfc00008);
    check_eq("t1_inst0", dlv_inst[0], 32'hcfc00000);
    check_eq("t1_inst2", dlv_inst[2], 32'hcfc00008);
    check_eq("t1_gap01", dlv_cyc[1] - dlv_cyc[0], 32'd1);
    check_eq("t1_gap12", dlv_cyc[2] - dlv_cyc[1], 32'd1);
    check_eq("t1_ex0", dlv_ex[0], 32'd0);

    // Back-pressure: queue fills, req drops, then drains in order
    ds_allowin = 1'b0;
    do_reset();
    run(10);
    check_eq("t2_acc", acc_log.size(), 32'd4);
    check_eq("t2_req", inst_sram_req, 32'd0);
    check_eq("t2_valid", fs_to_ds_valid, 32'd1);
    check_eq("t2_head_pc", fs_pc, 32'hbfc00000);
    check_eq("t2_head_inst", fs_inst, 32'hcfc00000);
    ds_allowin = 1'b1;
    run(8);
    check_eq("t2_pc0", dlv_pc[0], 32'hbfc00000);
    check_eq("t2_pc1", dlv_pc[1], 32'hbfc00004);
    check_eq("t2_pc2", dlv_pc[2], 32'hbfc00008);
    check_eq("t2_pc3", dlv_pc[3], 32'hbfc0000c);

    // Branch with two outstanding: keep delay slot only
    branch_setup(32'hbfc00100);
    check_eq("t3_ds", dlv_pc[4], 32'hbfc00010);
    check_eq("t3_tgt", dlv_pc[5], 32'hbfc00100);
    check_eq("t3_tgt1", dlv_pc[6], 32'hbfc00104);

    // Exception flush with two outstanding, 3-cycle latency
    ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; mem_lat = 3; mem_hold = 1'b0;
    do_reset();
    run(2);
    check_eq("t4_acc", acc_log.size(), 32'd2);
    check_eq("t4_none", dlv_pc.size(), 32'd0);
    ws_ex = 1'b1;
    run(1);
    ws_ex = 1'b0;
    run(14);
    check_eq("t4_pc", dlv_pc[0], 32'hbfc00380);
    check_eq("t4_inst", dlv_inst[0], 32'hcfc00380);
    check_eq("t4_acc2", acc_log[2], 32'hbfc00380);

    // eret and branch in the same cycle: eret wins
    mem_lat = 1;
    do_reset();
    run(4);
    ws_eret = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00100; cp0_epc = 32'hbfc00200;
    run(1);
    ws_eret = 1'b0; br_taken = 1'b0;
    idx = dlv_pc.size();
    run(10);
    check_eq("t5_pc0", dlv_pc[idx], 32'hbfc00200);
    check_eq("t5_pc1", dlv_pc[idx+1], 32'hbfc00204);
    check_eq("t5_inst0", dlv_inst[idx], 32'hcfc00200);

`ifdef FETCH_ADEL_CHECK_EN
    // Misaligned branch target raises AdEL after the delay slot
    branch_setup(32'hbfc00102);
    check_eq("t6_ds", dlv_pc[4], 32'hbfc00010);
    check_eq("t6_ds_ex", dlv_ex[4], 32'd0);
    check_eq("t6_pc", dlv_pc[5], 32'hbfc00102);
    check_eq("t6_ex", dlv_ex[5], 32'd1);
    check_eq("t6_code", dlv_code[5], 32'h04);
    check_eq("t6_inst", dlv_inst[5], 32'h0);
    n102 = 0;
    foreach (acc_log[i]) if (acc_log[i] == 32'hbfc00102) n102++;
    check_eq("t6_noreq", n102, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end
endmodule
